fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter for the async FIFO write domain. Shares one FIFO write
//  port (winc/wdata, gated by wfull/awfull from the write-pointer logic) among NREQ
//  valid/ready requesters. Optionally keeps the grant locked for a whole packet (until
//  last), so beats from different sources never interleave in the FIFO.
// PARAMETERS
//  NREQ       4  number of requesters, >=2; index width IW = $clog2(NREQ)
//  DSIZE      8  data width per requester and on wdata
//  PKT_MODE   1  1: hold grant until a beat with req_last; 0: one beat per grant
//  AFULL_HOLD 1  1: no new grant while awfull|wfull; 0: no new grant only while wfull
// PORTS
//  wclk       in   1           write-domain clock
//  wrst_n     in   1           asynchronous active-low reset
//  req_valid  in   NREQ        per-requester beat valid
//  req_last   in   NREQ        per-requester last beat of packet (ignored if PKT_MODE=0)
//  req_data   in   NREQ*DSIZE  flattened data, requester i at [i*DSIZE +: DSIZE]
//  req_ready  out  NREQ        per-requester accept; beat transfers when valid&ready
//  wfull      in   1           FIFO full (registered, from write-pointer logic)
//  awfull     in   1           FIFO almost full (one slot left)
//  winc       out  1           FIFO write strobe
//  wdata      out  DSIZE       FIFO write data
//  grant_idx  out  IW          index of the current/last granted requester
//  busy       out  1           high in state GRANT
// BEHAVIOUR
//  Reset (async, wrst_n=0): state=IDLE, rr_ptr=0, grant_idx=0, busy=0, req_ready=0,
//   winc=0; wdata is don't-care. Reset mid-packet truncates it; no winc is issued after
//   reset asserts. First grant after reset goes to requester 0 if it is valid.
//  FSM, two states:
//   IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ..., mod NREQ.
//    If a winner exists and the hold condition (wfull, or awfull|wfull if AFULL_HOLD) is
//    low: register grant_idx=winner and go to GRANT. Otherwise stay in IDLE. No transfer
//    happens in IDLE, so each grant costs one arbitration bubble.
//   GRANT: req_ready[g] = ~wfull for g=grant_idx; all other req_ready are 0.
//    winc = req_valid[g] & ~wfull, combinational. wdata = req_data[g].
//    The arbiter always gates winc with ~wfull and never relies on downstream gating.
//    Transfer = winc. End of grant: transfer AND (PKT_MODE==0 OR req_last[g]).
//    At end of grant: rr_ptr <= g+1 (wraps NREQ-1 -> 0) and the FSM returns to IDLE.
//    If req_valid[g] drops mid-packet, the grant holds (no timeout). wfull stalls in place.
//  Fairness: a requester that is still valid when its grant ends is searched last in the
//   next arbitration. Any continuously valid requester is served within NREQ grants.
//  Latency: valid in IDLE -> grant registered next edge -> first winc possible in that cycle.
//  Full boundary: wfull rising in GRANT deasserts ready/winc the same cycle. The grant is
//   kept, and the transfer resumes when wfull falls. Never more than one winc per cycle.
//  req_last in IDLE or on a non-transfer cycle is ignored.
//  grant_idx holds its value in IDLE. busy = (state==GRANT).
// TESTING
//  1. Reset, then req_valid=4'b0001, req_last=1, data=8'hA5 -> grant_idx=0 after 1 cycle;
//     winc=1, wdata=A5 on the 2nd cycle; back to IDLE; rr_ptr=1.
//  2. All 4 valid, PKT_MODE=0, FIFO never full -> grants 0,1,2,3,0... with one winc every
//     2 cycles.
//  3. PKT_MODE=1, req0 sends a 3-beat packet while req1 is valid -> 3 consecutive req0
//     beats, no req1 beat between them; req1 is granted next.
//  4. wfull=1 for 5 cycles mid-packet -> winc=0 and req_ready=0 during those cycles, grant
//     held; packet completes intact after wfull falls, FIFO contents in order.
//  5. AFULL_HOLD=1, awfull=1 in IDLE with req2 valid -> stays IDLE (busy=0) until awfull=0,
//     then grants 2.
//  6. wrst_n pulsed low during GRANT beat 2 of 4 -> winc=0 and req_ready=0 immediately;
//     after release the FSM is in IDLE with rr_ptr=0 and grant_idx=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Grants may be held for a whole packet so beats from different sources never mix.
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DSIZE      = 8,
  parameter int PKT_MODE   = 1,
  parameter int AFULL_HOLD = 1,
  localparam int IW        = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  input  logic                  awfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_idx,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   grant_q, grant_d;

  logic            hold;
  logic            found;
  logic [IW-1:0]   winner;
  logic            g_valid;
  logic            g_last;
  logic [DSIZE-1:0] g_data;
  logic            in_grant;
  logic            xfer;
  logic            grant_end;
  logic [IW-1:0]   grant_nxt;

  assign hold = (AFULL_HOLD != 0) ? (wfull | awfull) : wfull;

  // Scan from the far end so the entry closest to rr_q wins.
  always_comb begin
    logic [IW-1:0] idx;
    int            j;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    j      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = IW'(j);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign in_grant  = (state_q == GRANT);
  assign xfer      = in_grant & g_valid & ~wfull;
  assign grant_end = xfer & ((PKT_MODE == 0) | g_last);
  assign grant_nxt = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = in_grant & ~wfull & (grant_q == IW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found && !hold) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_end) begin
          rr_d    = grant_nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  assign winc      = xfer;
  assign wdata     = g_data;
  assign grant_idx = grant_q;
  assign busy      = in_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized packet traffic,
// checked by a per-cycle reference model and per-requester data scoreboard.
module tb_fifo_wr_arbiter;
  localparam int NREQ       = 4;
  localparam int DSIZE      = 8;
  localparam int PKT_MODE   = 1;
  localparam int AFULL_HOLD = 1;
  localparam int IW         = $clog2(NREQ);

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  awfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IW-1:0]         grant_idx;
  logic                  busy;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE),
    .PKT_MODE(PKT_MODE), .AFULL_HOLD(AFULL_HOLD)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .wfull(wfull), .awfull(awfull),
    .winc(winc), .wdata(wdata),
    .grant_idx(grant_idx), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DSIZE-1:0] exp_q [NREQ][$];
  logic [NREQ-1:0]  acc;
  logic             s_winc;
  int               left [NREQ];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int j = (rr + k) % NREQ;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  // Reference model: arbitration decisions come from what was visible at the
  // previous edge; data order comes from the per-requester queues.
  bit              m_busy = 0;
  int              m_g = 0;
  int              m_rr = 0;
  logic [NREQ-1:0] p_valid = '0;
  bit              p_hold = 0;
  bit              p_winc = 0;
  bit              p_last = 0;

  always @(negedge wclk) begin
    logic [NREQ-1:0] e_ready;
    bit              e_winc;
    if (!wrst_n) begin
      m_busy = 0; m_g = 0; m_rr = 0;
      p_valid = '0; p_hold = 0; p_winc = 0; p_last = 0;
    end else begin
      if (!m_busy) begin
        if (p_valid != '0 && !p_hold) begin
          m_busy = 1;
          m_g    = pick(p_valid, m_rr);
        end
      end else if (p_winc && (PKT_MODE == 0 || p_last)) begin
        m_busy = 0;
        m_rr   = (m_g + 1) % NREQ;
      end
      e_ready = (m_busy && !wfull) ? (NREQ'(1) << m_g) : '0;
      e_winc  = m_busy && req_valid[m_g] && !wfull;
      chk("busy", busy, m_busy);
      chk("grant_idx", grant_idx, m_g);
      chk("req_ready", req_ready, e_ready);
      chk("winc", winc, e_winc);
      if (e_winc) begin
        if (exp_q[m_g].size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("wdata", wdata, exp_q[m_g].pop_front());
        end
      end
      p_valid = req_valid;
      p_hold  = (AFULL_HOLD != 0) ? (wfull | awfull) : wfull;
      p_winc  = e_winc;
      p_last  = req_last[m_g];
    end
  end

  task automatic cycle();
    @(negedge wclk);
    acc    = req_valid & req_ready;
    s_winc = winc;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) req_valid[i] = 1'b0;
  endtask

  task automatic present(input int i, input logic [DSIZE-1:0] d,
                         input logic l);
    req_valid[i] = 1'b1;
    req_last[i]  = l;
    req_data[i*DSIZE +: DSIZE] = d;
    exp_q[i].push_back(d);
  endtask

  task automatic wait_acc(input int i);
    for (int n = 0; n < 60 && req_valid[i]; n++) cycle();
    chk("wait_acc_timeout", req_valid[i], 0);
  endtask

  task automatic rand_step(input bit gen);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i]) begin
        if (left[i] == 0 && gen && $urandom_range(0, 3) == 0)
          left[i] = $urandom_range(1, 4);
        if (left[i] != 0 && $urandom_range(0, 1) == 0) begin
          present(i, DSIZE'($urandom), left[i] == 1);
          left[i]--;
        end
      end
    end
  endtask

  initial begin
    int cnt;
    wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    wfull = 1'b0; awfull = 1'b0; acc = '0; s_winc = 1'b0;
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    repeat (3) @(posedge wclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_winc", winc, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_idx, 0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;

    // single beat from requester 0
    present(0, 8'hA5, 1'b1);
    cycle();
    chk("t1_grant", grant_idx, 0);
    chk("t1_winc", winc, 1);
    chk("t1_wdata", wdata, 8'hA5);
    wait_acc(0);
    chk("t1_idle", busy, 0);

    // all requesters continuously valid, single-beat packets
    for (int i = 0; i < NREQ; i++) present(i, DSIZE'($urandom), 1'b1);
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (s_winc) cnt++;
      if (c < 15)
        for (int i = 0; i < NREQ; i++)
          if (!req_valid[i]) present(i, DSIZE'($urandom), 1'b1);
    end
    chk("t2_winc_rate", cnt, 8);
    for (int i = 0; i < NREQ; i++) wait_acc(i);
    cycle();

    // 3-beat packet from req0 with req1 waiting and a full stall
    present(0, 8'h10, 1'b0);
    cycle();
    present(1, 8'h77, 1'b1);
    wait_acc(0);
    wfull = 1'b1;
    present(0, 8'h11, 1'b0);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (s_winc) cnt++;
    end
    chk("t4_stall_winc", cnt, 0);
    chk("t4_grant_held", grant_idx, 0);
    chk("t4_busy_held", busy, 1);
    wfull = 1'b0;
    wait_acc(0);
    present(0, 8'h12, 1'b1);
    wait_acc(0);
    wait_acc(1);
    chk("t3_next_grant", grant_idx, 1);
    cycle();

    // almost-full holds off a fresh grant
    awfull = 1'b1;
    present(2, 8'h5C, 1'b1);
    repeat (4) cycle();
    chk("t5_hold_idle", busy, 0);
    awfull = 1'b0;
    cycle();
    chk("t5_grant", grant_idx, 2);
    wait_acc(2);
    cycle();

    // reset in the middle of a 4-beat packet
    present(3, 8'h30, 1'b0);
    wait_acc(3);
    present(3, 8'h31, 1'b0);
    wait_acc(3);
    present(3, 8'h32, 1'b0);
    wrst_n = 1'b0;
    #1;
    chk("t6_winc", winc, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_grant", grant_idx, 0);
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    repeat (2) cycle();
    wrst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) present(i, DSIZE'(8'h40 + i), 1'b1);
    cycle();
    chk("t6_first_grant", grant_idx, 0);
    chk("t6_first_busy", busy, 1);
    for (int i = 0; i < NREQ; i++) wait_acc(i);

    // random traffic with random full/almost-full
    for (int c = 0; c < 3000; c++) begin
      wfull  = ($urandom_range(0, 4) == 0);
      awfull = ($urandom_range(0, 3) == 0);
      rand_step(1'b1);
      cycle();
    end
    wfull = 1'b0;
    awfull = 1'b0;
    for (int c = 0; c < 500; c++) begin
      bit pend = (req_valid != '0);
      for (int i = 0; i < NREQ; i++) if (left[i] != 0) pend = 1;
      if (!pend) break;
      rand_step(1'b0);
      cycle();
    end
    chk("drain_valid", req_valid, 0);
    repeat (3) cycle();
    for (int i = 0; i < NREQ; i++) chk("sb_leftover", exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
